fft_butterfly_pipe: RTL and testbench

//  Radix-2 DIT butterfly: y_N = x_N + w_N*x_M, y_M = x_N - w_N*x_M, true complex multiply.

---
 rtl/fft_butterfly_pipe.sv | 177 +++++++++++++++++
 tb/tb_fft_butterfly_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_pipe.sv
// fft_butterfly_pipe
//   Radix-2 decimation-in-time butterfly with a true complex multiply:
//     y_N = x_N + w_N * x_M,   y_M = x_N - w_N * x_M
//   Three pipeline stages. All stages move together when the output register
//   is empty or is being drained, so the pipe behaves as a single
//   elastic register chain.
//
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready = advance)
//   x_N, x_M              {re, im} signed integer samples, W bits each
//   w_N                   {re, im} twiddle, signed Q1.(W-1)
//   scale                 1: halve the result with round-half-up
//   out_valid / out_ready output handshake
//   y_N, y_M              {re, im} sum / difference results
//   ovf                   some component of this output was out of range
//   ovf_sticky, ovf_clr   accumulated ovf over handshaken outputs, sync clear
module fft_butterfly_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_N,
    input  logic [DATA_WIDTH-1:0] x_M,
    input  logic [DATA_WIDTH-1:0] w_N,
    input  logic                  scale,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] y_N,
    output logic [DATA_WIDTH-1:0] y_M,
    output logic                  ovf,
    output logic                  ovf_sticky,
    input  logic                  ovf_clr
);
    localparam int W      = DATA_WIDTH / 2;
    localparam int STAGES = 3;

    // Result range bounds at the widened W+3-bit working width.
    localparam logic signed [W+2:0] MAXV = {4'b0000, {(W-1){1'b1}}};
    localparam logic signed [W+2:0] MINV = {4'b1111, {(W-1){1'b0}}};
    // Half an LSB of the Q1.(W-1) product, for round-half-up.
    localparam logic signed [2*W:0] RND  = (2*W+1)'(1) <<< (W-2);

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] i;
    } cplx_t;

    logic               advance;

    logic [STAGES:1]    vld_pipe_q, vld_pipe_d;

    // S1
    cplx_t              xn1_q, xn1_d, xm1_q, xm1_d, w1_q, w1_d;
    logic               scl1_q, scl1_d;
    // S2
    cplx_t              xn2_q, xn2_d;
    logic signed [W+1:0] pr2_q, pr2_d, pi2_q, pi2_d;
    logic               scl2_q, scl2_d;
    // S3 / outputs
    logic [DATA_WIDTH-1:0] y_n_q, y_n_d, y_m_q, y_m_d;
    logic               ovf_q, ovf_d;
    logic               sticky_q, sticky_d;

    logic signed [2*W:0] pr_full, pi_full, pr_rnd, pi_rnd;
    // Components in order {N.r, N.i, M.r, M.i} at index 0..3.
    logic [3:0][W+1:0]  s_arr;
    logic [3:0][W-1:0]  y_arr;
    logic [3:0]         ovf_arr;

    assign advance    = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready   = advance;
    assign out_valid  = vld_pipe_q[STAGES];
    assign y_N        = y_n_q;
    assign y_M        = y_m_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

    // Stage-2 complex multiply at 2W+1 bits, then round and drop W-1 LSBs.
    always_comb begin
        pr_full = (2*W+1)'($signed(xm1_q.r)) * (2*W+1)'($signed(w1_q.r))
                - (2*W+1)'($signed(xm1_q.i)) * (2*W+1)'($signed(w1_q.i));
        pi_full = (2*W+1)'($signed(xm1_q.r)) * (2*W+1)'($signed(w1_q.i))
                + (2*W+1)'($signed(xm1_q.i)) * (2*W+1)'($signed(w1_q.r));
        pr_rnd  = pr_full + RND;
        pi_rnd  = pi_full + RND;
    end

    // Stage-3 sum / difference at W+2 bits.
    always_comb begin
        s_arr[0] = (W+2)'($signed(xn2_q.r)) + pr2_q;
        s_arr[1] = (W+2)'($signed(xn2_q.i)) + pi2_q;
        s_arr[2] = (W+2)'($signed(xn2_q.r)) - pr2_q;
        s_arr[3] = (W+2)'($signed(xn2_q.i)) - pi2_q;
    end

    // Per-component optional halving and reduction to W bits.
    for (genvar c = 0; c < 4; c++) begin : g_red
        logic signed [W+2:0] s_ext;
        logic signed [W+2:0] s_scl;
        assign s_ext      = {s_arr[c][W+1], s_arr[c]};
        assign s_scl      = scl2_q ? ((s_ext + (W+3)'(1)) >>> 1) : s_ext;
        assign ovf_arr[c] = (s_scl > MAXV) || (s_scl < MINV);
        assign y_arr[c]   = (ovf_arr[c] && SATURATE)
                          ? (s_scl[W+2] ? MINV[W-1:0] : MAXV[W-1:0])
                          : s_scl[W-1:0];
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        xn1_d      = xn1_q;
        xm1_d      = xm1_q;
        w1_d       = w1_q;
        scl1_d     = scl1_q;
        xn2_d      = xn2_q;
        pr2_d      = pr2_q;
        pi2_d      = pi2_q;
        scl2_d     = scl2_q;
        y_n_d      = y_n_q;
        y_m_d      = y_m_q;
        ovf_d      = ovf_q;
        if (advance) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
            xn1_d      = x_N;
            xm1_d      = x_M;
            w1_d       = w_N;
            scl1_d     = scale;
            xn2_d      = xn1_q;
            pr2_d      = pr_rnd[2*W:W-1];
            pi2_d      = pi_rnd[2*W:W-1];
            scl2_d     = scl1_q;
            y_n_d      = {y_arr[0], y_arr[1]};
            y_m_d      = {y_arr[2], y_arr[3]};
            ovf_d      = |ovf_arr;
        end
        // Set has priority over clear so a coincident overflow is never lost.
        sticky_d = sticky_q;
        if (ovf_clr)
            sticky_d = 1'b0;
        if (out_valid && out_ready && ovf_q)
            sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            xn1_q      <= '0;
            xm1_q      <= '0;
            w1_q       <= '0;
            scl1_q     <= 1'b0;
            xn2_q      <= '0;
            pr2_q      <= '0;
            pi2_q      <= '0;
            scl2_q     <= 1'b0;
            y_n_q      <= '0;
            y_m_q      <= '0;
            ovf_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            xn1_q      <= xn1_d;
            xm1_q      <= xm1_d;
            w1_q       <= w1_d;
            scl1_q     <= scl1_d;
            xn2_q      <= xn2_d;
            pr2_q      <= pr2_d;
            pi2_q      <= pi2_d;
            scl2_q     <= scl2_d;
            y_n_q      <= y_n_d;
            y_m_q      <= y_m_d;
            ovf_q      <= ovf_d;
            sticky_q   <= sticky_d;
        end
    end
endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Directed bench for fft_butterfly_pipe (DATA_WIDTH=32). A second instance
// with SATURATE=0 shares all inputs to check the wrap-around behaviour.
module tb_fft_butterfly_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, scale, ovf_clr;
    logic [31:0] x_N, x_M, w_N;
    logic        in_ready, out_valid, ovf, ovf_sticky;
    logic [31:0] y_N, y_M;
    logic        in_ready2, out_valid2, ovf2, ovf_sticky2;
    logic [31:0] y_N2, y_M2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fft_butterfly_pipe #(.DATA_WIDTH(32), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_N(x_N), .x_M(x_M), .w_N(w_N), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready), .y_N(y_N), .y_M(y_M),
        .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr));

    fft_butterfly_pipe #(.DATA_WIDTH(32), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x_N(x_N), .x_M(x_M), .w_N(w_N), .scale(scale),
        .out_valid(out_valid2), .out_ready(out_ready), .y_N(y_N2), .y_M(y_M2),
        .ovf(ovf2), .ovf_sticky(ovf_sticky2), .ovf_clr(ovf_clr));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cp(input logic [15:0] r, input logic [15:0] i);
        return {r, i};
    endfunction

    // Present one sample, then wait (bounded) for its result. Returns on the
    // negedge where out_valid is first seen, with out_ready=1.
    task automatic single(input string tag, input logic [31:0] xn, input logic [31:0] xm,
                          input logic [31:0] w, input logic sc,
                          input logic [31:0] eyn, input logic [31:0] eym, input logic eovf);
        int lat;
        @(negedge clk);
        x_N = xn; x_M = xm; w_N = w; scale = sc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd3);
        chk({tag, "_yN"}, 64'(y_N), 64'(eyn));
        chk({tag, "_yM"}, 64'(y_M), 64'(eym));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
    endtask

    initial begin
        logic [31:0] hold;
        int          got, cyc, acc;
        bit          skip, seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; scale = 1'b0; ovf_clr = 1'b0;
        x_N = '0; x_M = '0; w_N = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_yN", 64'(y_N), 64'd0);
        chk("rst_yM", 64'(y_M), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        single("real", cp(16'h1000, 0), cp(16'h2000, 0), cp(16'h7FFF, 0), 1'b0,
               cp(16'h3000, 0), cp(16'hF000, 0), 1'b0);
        single("real_scl", cp(16'h1000, 0), cp(16'h2000, 0), cp(16'h7FFF, 0), 1'b1,
               cp(16'h1800, 0), cp(16'hF800, 0), 1'b0);
        single("neg_j", cp(0, 0), cp(16'h1000, 0), cp(0, 16'h8000), 1'b0,
               cp(0, 16'hF000), cp(0, 16'h1000), 1'b0);
        chk("sticky_quiet", 64'(ovf_sticky), 64'd0);

        single("sat", cp(16'h7FFF, 0), cp(16'h7FFF, 0), cp(16'h7FFF, 0), 1'b0,
               cp(16'h7FFF, 0), cp(16'h0001, 0), 1'b1);
        chk("wrap_yN", 64'(y_N2), 64'(cp(16'hFFFD, 0)));
        chk("wrap_ovf", 64'(ovf2), 64'd1);
        chk("sticky_before_hs", 64'(ovf_sticky), 64'd0);
        @(negedge clk);
        chk("sticky_set", 64'(ovf_sticky), 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("sticky_clr", 64'(ovf_sticky), 64'd0);

        // Overflow handshake and clear on the same edge: set must win.
        single("sat2", cp(16'h7FFF, 0), cp(16'h7FFF, 0), cp(16'h7FFF, 0), 1'b0,
               cp(16'h7FFF, 0), cp(16'h0001, 0), 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // Backpressure: 6 samples with x_M=0 so each output equals x_N.
        @(negedge clk);
        fork
            begin : drv
                for (int k = 0; k < 6; k++) begin
                    int tmo;
                    x_N = cp(16'((k + 1) * 16'h0100), 16'(k));
                    x_M = '0; w_N = cp(16'h7FFF, 0); scale = 1'b0; in_valid = 1'b1;
                    #2;
                    tmo = 0;
                    while (!in_ready && tmo < 50) begin
                        @(negedge clk);
                        #2;
                        tmo++;
                    end
                    @(negedge clk);
                end
                in_valid = 1'b0;
            end
            begin : col
                got = 0; cyc = 0; skip = 1'b1;
                while (got < 6 && cyc < 200) begin
                    if (!skip) @(negedge clk);
                    skip = 1'b0;
                    cyc++;
                    if (out_valid && out_ready) begin
                        chk("bp_order", 64'(y_N), 64'(cp(16'((got + 1) * 16'h0100), 16'(got))));
                        got++;
                        if (got == 1) begin
                            @(negedge clk);
                            out_ready = 1'b0;
                            #1;
                            hold = y_N;
                            for (int s = 0; s < 4; s++) begin
                                chk("bp_in_ready", 64'(in_ready), 64'd0);
                                chk("bp_valid_held", 64'(out_valid), 64'd1);
                                chk("bp_frozen", 64'(y_N), 64'(hold));
                                @(negedge clk);
                            end
                            out_ready = 1'b1;
                            skip = 1'b1;
                        end
                    end
                end
                chk("bp_count", 64'(got), 64'd6);
            end
        join
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp_no_dup", 64'(seen), 64'd0);

        // Mid-flight reset: 3 samples accepted, then reset drops them.
        out_ready = 1'b0;
        acc = 0;
        x_N = cp(16'h0123, 0); x_M = '0; in_valid = 1'b1;
        while (acc < 3) begin
            @(negedge clk);
            acc++;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_stale", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
